xosera_bus_host: RTL and testbench
==================================

XOSERA_BUS_HOST -- requirements
Module: xosera_bus_host

Interface
REQ-001 The block SHALL have parameter SETUP_CYCLES, default 1: cycles with address, data and direction stable before bus_cs_n_o falls (range 1-15).
REQ-002 The block SHALL have parameter STROBE_CYCLES, default 4: cycles bus_cs_n_o is held low per byte (range 1-15).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 1: cycles address, data and direction stay stable after bus_cs_n_o rises (range 1-15).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port reset_n_i, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cmd_valid_i, input, width 1: command request.
REQ-007 The block SHALL have port cmd_ready_o, output, width 1: command accepted when cmd_valid_i and cmd_ready_o are both high on a clk edge.
REQ-008 The block SHALL have port cmd_rd_i, input, width 1: 1 = register read, 0 = register write.
REQ-009 The block SHALL have port cmd_reg_i, input, width 4: register number.
REQ-010 The block SHALL have port cmd_wdata_i, input, width 16: write word.
REQ-011 The block SHALL have port rsp_valid_o, output, width 1: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata_o, output, width 16: read word, valid while rsp_valid_o is high.
REQ-013 The block SHALL have ports bus_cs_n_o (width 1), bus_rd_nwr_o (width 1), bus_reg_num_o (width 4) and bus_bytesel_o (width 1), all outputs: the Xosera register-bus strobes.
REQ-014 The block SHALL have port bus_data_o, output, width 8: write byte.
REQ-015 The block SHALL have port bus_data_oe_o, output, width 1: enable for the host data driver.
REQ-016 The block SHALL have port bus_data_i, input, width 8: read byte from Xosera.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and DONE, plus a byte-phase flag (0 = even byte, 1 = odd byte).
REQ-018 cmd_ready_o SHALL be 1 only in IDLE; acceptance SHALL latch the command, clear the phase to 0 and go to SETUP.
REQ-019 SETUP SHALL last SETUP_CYCLES, STROBE SHALL last STROBE_CYCLES and HOLD SHALL last HOLD_CYCLES, using one 4-bit down-counter reloaded on every state entry.
REQ-020 After HOLD: if phase = 0, the block SHALL set phase to 1 and go to SETUP; if phase = 1, it SHALL go to DONE.
REQ-021 DONE SHALL last 1 cycle with rsp_valid_o = 1, then go to IDLE.
REQ-022 bus_cs_n_o SHALL be 0 only in STROBE and SHALL be registered (glitch-free).
REQ-023 bus_bytesel_o SHALL equal the phase in SETUP, STROBE and HOLD.
REQ-024 The even byte SHALL carry bits [15:8] and the odd byte bits [7:0] (big-endian).
REQ-025 bus_reg_num_o and bus_rd_nwr_o SHALL be driven from the latched command in SETUP, STROBE and HOLD.
REQ-026 bus_data_o SHALL be driven from the latched command in SETUP, STROBE and HOLD.
REQ-027 For writes, bus_data_oe_o SHALL be 1 in SETUP, STROBE and HOLD; for reads it SHALL be 0 at all times.
REQ-028 For reads, bus_data_i SHALL be sampled on the clk edge that ends the last STROBE cycle, into rsp_rdata_o[15:8] (phase 0) or [7:0] (phase 1).
REQ-029 rsp_rdata_o SHALL hold its value until the next read completes.
REQ-030 For writes, rsp_rdata_o SHALL be unchanged.
REQ-031 rsp_valid_o SHALL go high in the cycle 2*(SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES)+1 after the acceptance edge (13 with default parameters).
REQ-032 A new command SHALL be acceptable no earlier than the cycle after DONE.
REQ-033 cmd_valid_i toggling outside IDLE SHALL be ignored.
REQ-034 The latched command SHALL be immune to cmd_* changes after acceptance.
REQ-035 In IDLE and DONE the block SHALL drive bus_cs_n_o = 1, bus_rd_nwr_o = 1 and bus_data_oe_o = 0; the other bus outputs SHALL hold their last values.
REQ-036 A parameter outside 1-15 SHALL be an elaboration error.

Reset
REQ-037 While reset_n_i = 0, the block SHALL immediately (asynchronously) drive state = IDLE, phase = 0, bus_cs_n_o = 1 and bus_rd_nwr_o = 1.
REQ-038 While reset_n_i = 0, the block SHALL drive bus_data_oe_o = 0, bus_reg_num_o = 0, bus_bytesel_o = 0 and bus_data_o = 0.
REQ-039 While reset_n_i = 0, the block SHALL drive rsp_valid_o = 0, rsp_rdata_o = 0, cmd_ready_o = 0 and counter = 0.
REQ-040 Reset mid-transaction SHALL abort it: cs_n high the same cycle, no rsp_valid_o pulse, no partial data reported.
REQ-041 cmd_ready_o SHALL first assert in the first cycle after reset_n_i is sampled high.

Structure
REQ-042 The state enum and the BUS_EVEN_IS_HIGH byte-order constant SHALL live in the shared xv package.
REQ-043 Parameter range checks SHALL be local to the block.
REQ-044 The block SHALL be a single module with no sub-module; the timing counter SHALL be inline.

Verification
REQ-045 The bench SHALL cover: write reg 3 = 0xABCD with defaults -> two cs_n low pulses of 4 cycles; bytesel 0 with data 0xAB, then 1 with 0xCD; oe = 1 in SETUP, STROBE and HOLD; rsp_valid_o in cycle 13.
REQ-046 The bench SHALL cover: read reg 5 with bus_data_i = 0x12 then 0x34 -> rsp_rdata_o = 0x1234; bus_rd_nwr_o = 1; oe = 0 throughout.
REQ-047 The bench SHALL cover: SETUP = 2, STROBE = 1, HOLD = 3 -> cs_n low exactly 1 cycle per byte; rsp_valid_o in cycle 13.
REQ-048 The bench SHALL cover: cmd_valid_i held high continuously for 3 commands -> cmd_ready_o pulses once per command; commands execute in order with no overlap.
REQ-049 The bench SHALL cover: reset_n_i asserted during STROBE of the odd byte -> cs_n = 1 immediately; no rsp_valid_o; after release cmd_ready_o = 1 and the next write completes normally.
REQ-050 The bench SHALL cover: cmd_wdata_i changed the cycle after acceptance -> bus_data_o shows the original value.

Source files
------------

// File: rtl/xosera_bus_host_pkg.sv
// Shared definitions for the Xosera register-bus host: FSM states and byte
// ordering of 16-bit register words on the 8-bit bus.
package xv;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } bus_state_e;

    // Even byte (bytesel = 0) carries the high half of the word.
    localparam bit BUS_EVEN_IS_HIGH = 1'b1;

    function automatic logic [7:0] bus_byte(input logic [15:0] word, input logic odd);
        if (odd == BUS_EVEN_IS_HIGH) begin
            return word[7:0];
        end
        return word[15:8];
    endfunction

endpackage

// File: rtl/xosera_bus_host.sv
// Host-side master for the Xosera 8-bit register bus: splits one 16-bit register
// access into two byte cycles, each with setup, chip-select strobe and hold.
module xosera_bus_host
    import xv::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rd_i,
    input  logic [3:0]  cmd_reg_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("xosera_bus_host: SETUP_CYCLES must be 1..15");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("xosera_bus_host: STROBE_CYCLES must be 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("xosera_bus_host: HOLD_CYCLES must be 1..15");
    end

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cmd_rd_q, cmd_rd_d;
    logic [3:0]  cmd_reg_q, cmd_reg_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic [7:0]  rd_even_q, rd_even_d;
    logic [7:0]  rd_odd_q, rd_odd_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_nwr_q, rd_nwr_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic        bytesel_q, bytesel_d;
    logic [7:0]  data_q, data_d;
    logic        oe_q, oe_d;
    logic        bus_active;
    logic        sample_rd;

    assign sample_rd = (state_q == STROBE) && (cnt_q == 4'd0) && cmd_rd_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_wdata_d = cmd_wdata_q;
        rd_even_d   = rd_even_q;
        rd_odd_d    = rd_odd_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                // ready_q gates acceptance so nothing is taken in the first cycle out of reset.
                if (cmd_valid_i && ready_q) begin
                    cmd_rd_d    = cmd_rd_i;
                    cmd_reg_d   = cmd_reg_i;
                    cmd_wdata_d = cmd_wdata_i;
                    phase_d     = 1'b0;
                    state_d     = SETUP;
                    cnt_d       = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (sample_rd) begin
                    if (phase_q) begin
                        rd_odd_d = bus_data_i;
                    end else begin
                        rd_even_d = bus_data_i;
                    end
                end
            end
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                end else begin
                    state_d     = DONE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                    // The response word only changes once both bytes of a read are in.
                    if (cmd_rd_q) begin
                        rsp_rdata_d = BUS_EVEN_IS_HIGH ? {rd_even_q, rd_odd_q}
                                                       : {rd_odd_q, rd_even_q};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus outputs are registered from the next state so they align with state_q.
        bus_active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        ready_d    = (state_d == IDLE);
        cs_n_d     = (state_d != STROBE);
        rd_nwr_d   = 1'b1;
        oe_d       = 1'b0;
        reg_num_d  = reg_num_q;
        bytesel_d  = bytesel_q;
        data_d     = data_q;
        if (bus_active) begin
            rd_nwr_d  = cmd_rd_d;
            oe_d      = !cmd_rd_d;
            reg_num_d = cmd_reg_d;
            bytesel_d = phase_d;
            data_d    = bus_byte(cmd_wdata_d, phase_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            cs_n_q      <= 1'b1;
            rd_nwr_q    <= 1'b1;
            reg_num_q   <= 4'd0;
            bytesel_q   <= 1'b0;
            data_q      <= 8'h00;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            cs_n_q      <= cs_n_d;
            rd_nwr_q    <= rd_nwr_d;
            reg_num_q   <= reg_num_d;
            bytesel_q   <= bytesel_d;
            data_q      <= data_d;
            oe_q        <= oe_d;
        end
    end

    // Command and read-byte holding registers need no reset: they are always
    // written before being used.
    always_ff @(posedge clk) begin
        cmd_rd_q    <= cmd_rd_d;
        cmd_reg_q   <= cmd_reg_d;
        cmd_wdata_q <= cmd_wdata_d;
        rd_even_q   <= rd_even_d;
        rd_odd_q    <= rd_odd_d;
    end

    assign cmd_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign bus_cs_n_o    = cs_n_q;
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_reg_num_o = reg_num_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_data_o    = data_q;
    assign bus_data_oe_o = oe_q;

endmodule

// File: tb/tb_xosera_bus_host.sv
// Directed bench for xosera_bus_host: default-timing instance u0 and a
// SETUP=2/STROBE=1/HOLD=3 instance u1 sharing command and bus inputs.
module tb_xosera_bus_host;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cv0, cv1;
    logic        cmd_rd;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic [7:0]  bus_din;

    logic        rdy0, rv0, cs0, rnw0, bsel0, oe0;
    logic [15:0] rdata0;
    logic [3:0]  reg0;
    logic [7:0]  dout0;
    logic        rdy1, rv1, cs1, rnw1, bsel1, oe1;
    logic [15:0] rdata1;
    logic [3:0]  reg1;
    logic [7:0]  dout1;

    int          sel;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_rd [2];

    logic        m_rdy, m_rv, m_cs, m_rnw, m_bsel, m_oe;
    logic [15:0] m_rdata;
    logic [3:0]  m_reg;
    logic [7:0]  m_dout;

    always #5 clk = ~clk;

    xosera_bus_host u0 (
        .clk(clk), .reset_n_i(reset_n),
        .cmd_valid_i(cv0), .cmd_ready_o(rdy0), .cmd_rd_i(cmd_rd),
        .cmd_reg_i(cmd_reg), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rv0), .rsp_rdata_o(rdata0),
        .bus_cs_n_o(cs0), .bus_rd_nwr_o(rnw0), .bus_reg_num_o(reg0),
        .bus_bytesel_o(bsel0), .bus_data_o(dout0), .bus_data_oe_o(oe0),
        .bus_data_i(bus_din)
    );

    xosera_bus_host #(.SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3)) u1 (
        .clk(clk), .reset_n_i(reset_n),
        .cmd_valid_i(cv1), .cmd_ready_o(rdy1), .cmd_rd_i(cmd_rd),
        .cmd_reg_i(cmd_reg), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rv1), .rsp_rdata_o(rdata1),
        .bus_cs_n_o(cs1), .bus_rd_nwr_o(rnw1), .bus_reg_num_o(reg1),
        .bus_bytesel_o(bsel1), .bus_data_o(dout1), .bus_data_oe_o(oe1),
        .bus_data_i(bus_din)
    );

    assign m_rdy   = (sel == 1) ? rdy1   : rdy0;
    assign m_rv    = (sel == 1) ? rv1    : rv0;
    assign m_cs    = (sel == 1) ? cs1    : cs0;
    assign m_rnw   = (sel == 1) ? rnw1   : rnw0;
    assign m_bsel  = (sel == 1) ? bsel1  : bsel0;
    assign m_oe    = (sel == 1) ? oe1    : oe0;
    assign m_rdata = (sel == 1) ? rdata1 : rdata0;
    assign m_reg   = (sel == 1) ? reg1   : reg0;
    assign m_dout  = (sel == 1) ? dout1  : dout0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel == 1) cv1 = v;
        else          cv0 = v;
    endtask

    // Call at a negedge while the selected instance is idle; acceptance is the next posedge.
    task automatic issue(input logic rd, input logic [3:0] r, input logic [15:0] w);
        chk("issue ready", 16'(m_rdy), 16'h0001);
        cmd_rd    = rd;
        cmd_reg   = r;
        cmd_wdata = w;
        set_valid(1'b1);
    endtask

    // Walks cycles 1..len after acceptance against a hand-written phase string:
    // S = setup, P = strobe (cs_n low), H = hold, D = done. At cycle 1 the
    // command inputs switch to the n* values to probe latching and back-to-back.
    task automatic trace(input string name, input string pat, input logic rd,
                         input logic [3:0] r, input logic [15:0] w,
                         input logic nv, input logic nrd, input logic [3:0] nr,
                         input logic [15:0] nw);
        int half;
        half = (pat.len() - 1) / 2;
        for (int k = 1; k <= pat.len(); k++) begin
            byte  c;
            logic odd;
            c   = pat[k-1];
            odd = (k > half);
            @(negedge clk);
            if (k == 1) begin
                set_valid(nv);
                cmd_rd    = nrd;
                cmd_reg   = nr;
                cmd_wdata = nw;
            end
            bus_din = rd ? (odd ? w[7:0] : w[15:8]) : 8'hEE;
            chk($sformatf("%s k=%0d cs_n", name, k), 16'(m_cs), 16'(c != "P"));
            chk($sformatf("%s k=%0d oe", name, k), 16'(m_oe), 16'(!rd && (c != "D")));
            chk($sformatf("%s k=%0d rsp_valid", name, k), 16'(m_rv), 16'(c == "D"));
            chk($sformatf("%s k=%0d ready", name, k), 16'(m_rdy), 16'h0000);
            if (c != "D") begin
                chk($sformatf("%s k=%0d rd_nwr", name, k), 16'(m_rnw), 16'(rd));
                chk($sformatf("%s k=%0d reg", name, k), 16'(m_reg), 16'(r));
                chk($sformatf("%s k=%0d bytesel", name, k), 16'(m_bsel), 16'(odd));
                if (!rd) begin
                    chk($sformatf("%s k=%0d data", name, k), 16'(m_dout),
                        16'(odd ? w[7:0] : w[15:8]));
                end
            end else begin
                chk($sformatf("%s done rd_nwr", name), 16'(m_rnw), 16'h0001);
                if (rd) last_rd[sel] = w;
                chk($sformatf("%s done rdata", name), m_rdata, last_rd[sel]);
            end
        end
        @(negedge clk);
        chk($sformatf("%s ready after done", name), 16'(m_rdy), 16'h0001);
    endtask

    initial begin
        int pulses;
        reset_n    = 1'b1;
        cv0        = 1'b0;
        cv1        = 1'b0;
        cmd_rd     = 1'b0;
        cmd_reg    = 4'd0;
        cmd_wdata  = 16'h0000;
        bus_din    = 8'h00;
        sel        = 0;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        pulses     = 0;

        // ---- reset values
        #1 reset_n = 1'b0;
        #1;
        chk("rst cs_n", 16'(cs0), 16'h0001);
        chk("rst rd_nwr", 16'(rnw0), 16'h0001);
        chk("rst oe", 16'(oe0), 16'h0000);
        chk("rst reg", 16'(reg0), 16'h0000);
        chk("rst bytesel", 16'(bsel0), 16'h0000);
        chk("rst data", 16'(dout0), 16'h0000);
        chk("rst rsp_valid", 16'(rv0), 16'h0000);
        chk("rst rdata", rdata0, 16'h0000);
        chk("rst ready", 16'(rdy0), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready after release", 16'(rdy0), 16'h0001);

        // ---- write reg 3 = 0xABCD, default timing
        issue(1'b0, 4'd3, 16'hABCD);
        trace("wr_abcd", "SPPPPHSPPPPHD", 1'b0, 4'd3, 16'hABCD, 1'b0, 1'b0, 4'd3, 16'hABCD);

        // ---- read reg 5, bus returns 0x12 then 0x34
        issue(1'b1, 4'd5, 16'h0000);
        trace("rd_1234", "SPPPPHSPPPPHD", 1'b1, 4'd5, 16'h1234, 1'b0, 1'b1, 4'd5, 16'h0000);

        // ---- command inputs scrambled right after acceptance; rdata must stay 0x1234
        issue(1'b0, 4'd9, 16'h5AC3);
        trace("wr_latch", "SPPPPHSPPPPHD", 1'b0, 4'd9, 16'h5AC3, 1'b0, 1'b1, 4'd6, 16'h0000);

        // ---- cmd_valid held high across three commands
        issue(1'b0, 4'd1, 16'h1111);
        trace("b2b_a", "SPPPPHSPPPPHD", 1'b0, 4'd1, 16'h1111, 1'b1, 1'b1, 4'd2, 16'h0000);
        trace("b2b_b", "SPPPPHSPPPPHD", 1'b1, 4'd2, 16'h5566, 1'b1, 1'b0, 4'd4, 16'h7788);
        trace("b2b_c", "SPPPPHSPPPPHD", 1'b0, 4'd4, 16'h7788, 1'b0, 1'b0, 4'd4, 16'h7788);

        // ---- SETUP=2, STROBE=1, HOLD=3 instance
        sel = 1;
        issue(1'b0, 4'd7, 16'hBEEF);
        trace("p_wr", "SSPHHHSSPHHHD", 1'b0, 4'd7, 16'hBEEF, 1'b0, 1'b0, 4'd7, 16'hBEEF);
        issue(1'b1, 4'd6, 16'h0000);
        trace("p_rd", "SSPHHHSSPHHHD", 1'b1, 4'd6, 16'h9A0F, 1'b0, 1'b1, 4'd6, 16'h0000);
        sel = 0;

        // ---- reset during strobe of the odd byte
        issue(1'b0, 4'd2, 16'h1357);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) set_valid(1'b0);
        end
        chk("pre-reset cs_n", 16'(cs0), 16'h0000);
        chk("pre-reset bytesel", 16'(bsel0), 16'h0001);
        #1 reset_n = 1'b0;
        #1;
        chk("abort cs_n", 16'(cs0), 16'h0001);
        chk("abort rd_nwr", 16'(rnw0), 16'h0001);
        chk("abort oe", 16'(oe0), 16'h0000);
        chk("abort bytesel", 16'(bsel0), 16'h0000);
        chk("abort data", 16'(dout0), 16'h0000);
        chk("abort ready", 16'(rdy0), 16'h0000);
        chk("abort rdata", rdata0, 16'h0000);
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv0) pulses++;
            if (i == 3) reset_n = 1'b1;
            if (i == 4) chk("ready after abort", 16'(rdy0), 16'h0001);
        end
        chk("no rsp after abort", 16'(pulses), 16'h0000);

        // ---- normal write after the aborted one
        issue(1'b0, 4'd11, 16'h2468);
        trace("wr_after", "SPPPPHSPPPPHD", 1'b0, 4'd11, 16'h2468, 1'b0, 1'b0, 4'd11, 16'h2468);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
